// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: shares one AES core between two requesters.
// Round-robin grant, one-cycle START, operand hold, watchdog abort.
//
// Ports:
//   CLK, nRST                 clock, async active-low reset
//   i_reqN_valid/o_reqN_ready job handshake, port N (0/1)
//   i_reqN_encdec/_key/_text  job operands (encdec 1 = decrypt)
//   o_rspN_valid/i_rspN_ready result handshake, port N
//   o_rspN_text/o_rspN_err    result block, watchdog abort flag
//   o_aes_start/_encdec/_key/_textin   core command side
//   i_aes_done/i_aes_textout  core completion side
//   o_busy, o_owner           not IDLE, port owning current job
module aes_job_scheduler #(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         i_req0_valid,
    output logic         o_req0_ready,
    input  logic         i_req0_encdec,
    input  logic [127:0] i_req0_key,
    input  logic [127:0] i_req0_text,
    input  logic         i_req1_valid,
    output logic         o_req1_ready,
    input  logic         i_req1_encdec,
    input  logic [127:0] i_req1_key,
    input  logic [127:0] i_req1_text,
    output logic         o_rsp0_valid,
    input  logic         i_rsp0_ready,
    output logic [127:0] o_rsp0_text,
    output logic         o_rsp0_err,
    output logic         o_rsp1_valid,
    input  logic         i_rsp1_ready,
    output logic [127:0] o_rsp1_text,
    output logic         o_rsp1_err,
    output logic         o_aes_start,
    output logic         o_aes_encdec,
    output logic [127:0] o_aes_key,
    output logic [127:0] o_aes_textin,
    input  logic         i_aes_done,
    input  logic [127:0] i_aes_textout,
    output logic         o_busy,
    output logic         o_owner
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    logic [1:0]   r_state;
    logic         r_last_grant;
    logic         r_owner;
    logic         r_encdec;
    logic [127:0] r_key;
    logic [127:0] r_text;
    logic [127:0] r_result;
    logic         r_err;
    logic [7:0]   r_cnt;

    logic w_idle;
    logic w_resp;
    logic w_gnt0;
    logic w_gnt1;
    logic w_rsp_hs;

    assign w_idle = (r_state == S_IDLE);
    assign w_resp = (r_state == S_RESP);

    // On contention the port that did not win last time is granted.
    assign w_gnt0 = i_req0_valid & (~i_req1_valid | r_last_grant);
    assign w_gnt1 = i_req1_valid & (~i_req0_valid | ~r_last_grant);

    assign w_rsp_hs = r_owner ? i_rsp1_ready : i_rsp0_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_encdec     <= 1'b0;
            r_key        <= '0;
            r_text       <= '0;
            r_result     <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 | w_gnt1) begin
                        r_owner  <= w_gnt1;
                        r_encdec <= w_gnt1 ? i_req1_encdec : i_req0_encdec;
                        r_key    <= w_gnt1 ? i_req1_key : i_req0_key;
                        r_text   <= w_gnt1 ? i_req1_text : i_req0_text;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    // DONE takes priority over a coincident timeout.
                    if (i_aes_done) begin
                        r_result <= i_aes_textout;
                        r_err    <= 1'b0;
                        r_state  <= S_RESP;
                    end else if (r_cnt == TMO) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_last_grant <= r_owner;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req0_ready = w_idle & w_gnt0;
    assign o_req1_ready = w_idle & w_gnt1;

    assign o_rsp0_valid = w_resp & ~r_owner;
    assign o_rsp1_valid = w_resp & r_owner;
    assign o_rsp0_text  = o_rsp0_valid ? r_result : '0;
    assign o_rsp1_text  = o_rsp1_valid ? r_result : '0;
    assign o_rsp0_err   = o_rsp0_valid & r_err;
    assign o_rsp1_err   = o_rsp1_valid & r_err;

    assign o_aes_start  = (r_state == S_ISSUE);
    assign o_aes_encdec = r_encdec;
    assign o_aes_key    = r_key;
    assign o_aes_textin = r_text;

    assign o_busy  = ~w_idle;
    assign o_owner = r_owner;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// tb_aes_job_scheduler: directed bench for aes_job_scheduler.
// Behavioural core model with fixed enc/dec latency and known vectors.
module tb_aes_job_scheduler;

    localparam logic [127:0] K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_ready;
    logic [1:0]   req_encdec = '0;
    logic [127:0] req_key [2];
    logic [127:0] req_text [2];
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready = '0;
    logic [127:0] rsp_text [2];
    logic [1:0]   rsp_err;
    logic         aes_start;
    logic         aes_encdec;
    logic [127:0] aes_key;
    logic [127:0] aes_textin;
    logic         aes_done;
    logic [127:0] aes_textout;
    logic         busy;
    logic         owner;

    logic         core_done = 1'b0;
    logic [127:0] core_text = '0;
    logic         inj_done = 1'b0;
    logic [127:0] inj_text = '0;
    bit           core_mute = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    assign aes_done    = core_done | inj_done;
    assign aes_textout = inj_done ? inj_text : core_text;

    always #5 CLK = ~CLK;

    aes_job_scheduler #(.TIMEOUT(40)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .i_req0_valid(req_valid[0]),
        .o_req0_ready(req_ready[0]),
        .i_req0_encdec(req_encdec[0]),
        .i_req0_key(req_key[0]),
        .i_req0_text(req_text[0]),
        .i_req1_valid(req_valid[1]),
        .o_req1_ready(req_ready[1]),
        .i_req1_encdec(req_encdec[1]),
        .i_req1_key(req_key[1]),
        .i_req1_text(req_text[1]),
        .o_rsp0_valid(rsp_valid[0]),
        .i_rsp0_ready(rsp_ready[0]),
        .o_rsp0_text(rsp_text[0]),
        .o_rsp0_err(rsp_err[0]),
        .o_rsp1_valid(rsp_valid[1]),
        .i_rsp1_ready(rsp_ready[1]),
        .o_rsp1_text(rsp_text[1]),
        .o_rsp1_err(rsp_err[1]),
        .o_aes_start(aes_start),
        .o_aes_encdec(aes_encdec),
        .o_aes_key(aes_key),
        .o_aes_textin(aes_textin),
        .i_aes_done(aes_done),
        .i_aes_textout(aes_textout),
        .o_busy(busy),
        .o_owner(owner)
    );

    // Known FIPS-197 pair, otherwise the "core" just inverts the block.
    function automatic logic [127:0] core_fn(input logic ed,
                                             input logic [127:0] k,
                                             input logic [127:0] t);
        if (!ed && k == K && t == P) return C;
        if (ed && k == K && t == C) return P;
        return ~t;
    endfunction

    // Core model: DONE in the 11th (enc) / 22nd (dec) cycle after START.
    initial begin
        int cd;
        logic ed_l;
        logic [127:0] key_l;
        logic [127:0] txt_l;
        cd = 0;
        ed_l = 1'b0;
        key_l = '0;
        txt_l = '0;
        forever begin
            @(negedge CLK);
            core_done = 1'b0;
            if (!nRST) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        core_done = 1'b1;
                        core_text = core_fn(ed_l, key_l, txt_l);
                    end
                end
                if (aes_start && !core_mute) begin
                    cd = aes_encdec ? 22 : 11;
                    ed_l = aes_encdec;
                    key_l = aes_key;
                    txt_l = aes_textin;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no end, required $finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic wait_rsp(input int p, input logic [127:0] exp,
                            input bit eerr, input int elat,
                            input int lat0);
        int lat;
        lat = lat0;
        while (!rsp_valid[p] && lat < 200) begin
            tick();
            lat++;
        end
        chk("rsp_latency", lat, elat);
        chk("rsp_text", rsp_text[p], exp);
        chk("rsp_err", rsp_err[p], eerr);
        chk("rsp_owner", owner, p);
        chk("rsp_other_quiet", {rsp_valid[1-p], rsp_err[1-p]}, 0);
        tick();
        chk("rsp_dropped", rsp_valid[p], 0);
    endtask

    task automatic run_job(input int p, input bit ed,
                           input logic [127:0] key,
                           input logic [127:0] txt,
                           input logic [127:0] exp, input bit eerr,
                           input int elat, output int acc_w);
        int w;
        rsp_ready[p] = 1'b1;
        tick();
        req_encdec[p] = ed;
        req_key[p] = key;
        req_text[p] = txt;
        req_valid[p] = 1'b1;
        #1;
        w = 0;
        while (!req_ready[p] && w < 50) begin
            tick();
            w++;
        end
        chk("accept_bound", w < 50, 1);
        acc_w = w;
        tick();
        req_valid[p] = 1'b0;
        wait_rsp(p, exp, eerr, elat, 1);
    endtask

    typedef struct {
        int           port;
        bit           ed;
        logic [127:0] key;
        logic [127:0] text;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int w;
        int n_acc;
        int n_rsp;
        int run;
        bit in_job;
        bit drop;
        bit viol;
        int lat;

        tbl[0] = '{0, 1'b0, K, P, C, 13};
        tbl[1] = '{1, 1'b1, K, C, P, 24};
        tbl[2] = '{1, 1'b0, 128'h0, 128'h0,
                   128'hffffffff_ffffffff_ffffffff_ffffffff, 13};
        tbl[3] = '{0, 1'b1, K,
                   128'hffff0000_ffff0000_ffff0000_ffff0000,
                   128'h0000ffff_0000ffff_0000ffff_0000ffff, 24};

        req_key[0] = '0;
        req_key[1] = '0;
        req_text[0] = '0;
        req_text[1] = '0;

        // Reset state
        tick();
        tick();
        chk("reset_ctrl", {req_ready, rsp_valid, rsp_err, aes_start,
                           aes_encdec, busy, owner}, 0);
        chk("reset_data", rsp_text[0] | rsp_text[1] | aes_key |
                          aes_textin, 0);
        nRST = 1'b1;
        tick();
        chk("post_reset_busy", busy, 0);

        // Contention: 4 jobs, grants must alternate 0,1,0,1
        req_encdec = 2'b00;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        n_acc = 0;
        n_rsp = 0;
        run = 0;
        in_job = 1'b0;
        drop = 1'b0;
        #1;
        for (int c = 0; c < 200 && n_rsp < 4; c++) begin
            if (aes_start) begin
                run++;
            end else if (run != 0) begin
                chk("start_width", run, 1);
                run = 0;
            end
            if (in_job) chk("busy_in_job", busy, 1);
            if (|(rsp_valid & rsp_ready)) begin
                in_job = 1'b0;
                n_rsp++;
            end
            if (|(req_valid & req_ready)) begin
                chk("grant_order", req_ready[1], n_acc % 2);
                chk("grant_onehot", req_ready[0] ^ req_ready[1], 1);
                n_acc++;
                in_job = 1'b1;
                if (n_acc == 4) drop = 1'b1;
            end else if (drop) begin
                req_valid = 2'b00;
            end
            tick();
        end
        req_valid = 2'b00;
        chk("contention_jobs", n_rsp, 4);

        // Table-driven single jobs
        for (int i = 0; i < 4; i++) begin
            run_job(tbl[i].port, tbl[i].ed, tbl[i].key, tbl[i].text,
                    tbl[i].exp, 1'b0, tbl[i].lat, w);
        end

        // Watchdog abort, then late DONE while idle
        core_mute = 1'b1;
        run_job(0, 1'b0, K, P, 128'h0, 1'b1, 43, w);
        core_mute = 1'b0;
        repeat (5) tick();
        inj_text = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_done_ignored", {rsp_valid, busy}, 0);
            tick();
        end
        run_job(0, 1'b0, K, P, C, 1'b0, 13, w);

        // Response backpressure with port 1 pending
        rsp_ready = 2'b00;
        tick();
        req_encdec[0] = 1'b0;
        req_key[0] = K;
        req_text[0] = P;
        req_valid[0] = 1'b1;
        #1;
        w = 0;
        while (!req_ready[0] && w < 50) begin
            tick();
            w++;
        end
        tick();
        req_valid[0] = 1'b0;
        req_encdec[1] = 1'b0;
        req_key[1] = K;
        req_text[1] = P;
        req_valid[1] = 1'b1;
        #1;
        lat = 1;
        viol = 1'b0;
        while (!rsp_valid[0] && lat < 200) begin
            viol |= req_ready[1];
            tick();
            lat++;
        end
        chk("bp_latency", lat, 13);
        chk("bp_req1_blocked_wait", viol, 0);
        for (int i = 0; i < 20; i++) begin
            chk("bp_hold", {rsp_valid[0], rsp_text[0], req_ready[1]},
                {1'b1, C, 1'b0});
            tick();
        end
        chk("bp_req1_blocked_last", req_ready[1], 0);
        rsp_ready[0] = 1'b1;
        tick();
        chk("bp_req1_after_hs", {req_ready[1], rsp_valid[0]}, 2'b10);
        rsp_ready = 2'b10;
        tick();
        req_valid[1] = 1'b0;
        wait_rsp(1, C, 1'b0, 13, 1);

        // Reset in the middle of WAIT
        run_job(0, 1'b0, K, P, C, 1'b0, 13, w);
        tick();
        req_encdec[0] = 1'b1;
        req_key[0] = K;
        req_text[0] = C;
        req_valid[0] = 1'b1;
        #1;
        w = 0;
        while (!req_ready[0] && w < 50) begin
            tick();
            w++;
        end
        tick();
        req_valid[0] = 1'b0;
        repeat (4) tick();
        chk("midop_busy", busy, 1);
        nRST = 1'b0;
        #1;
        chk("midop_rst_ctrl", {req_ready, rsp_valid, rsp_err, aes_start,
                               aes_encdec, busy, owner}, 0);
        chk("midop_rst_data", rsp_text[0] | rsp_text[1] | aes_key |
                              aes_textin, 0);
        tick();
        tick();
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midop_no_rsp", {rsp_valid, busy}, 0);
        end
        req_encdec = 2'b00;
        req_key[0] = K;
        req_key[1] = K;
        req_text[0] = P;
        req_text[1] = P;
        req_valid = 2'b11;
        #1;
        chk("midop_contention", req_ready, 2'b01);
        req_valid = 2'b00;
        #1;
        run_job(1, 1'b1, K, C, P, 1'b0, 24, w);
        chk("midop_req1_first_try", w, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
